// File: rtl/viterbi_pkg.sv
// Shared trellis parameters, derived widths and scheduler state type for the
// folded Viterbi ACS sequencer.
package viterbi_pkg;
    localparam int NUM_STATES = 64;
    localparam int PAR        = 8;
    localparam int TB_DEPTH   = 32;
    localparam int G          = NUM_STATES / (2 * PAR);
    localparam int GW         = (G > 1) ? $clog2(G) : 1;
    localparam int AW         = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        TB_WAIT = 2'd2
    } sched_state_e;

    function automatic logic is_last_group(input logic [GW-1:0] grp);
        return grp == GW'(G - 1);
    endfunction
endpackage

// File: rtl/viterbi_sp_addr_ctr.sv
// Survivor-memory column counter (mod TB_DEPTH); wrap flags the last column of
// the traceback window.
module viterbi_sp_addr_ctr
    import viterbi_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    output logic [AW-1:0] addr,
    output logic          wrap
);
    // Column pointer, advanced once per completed symbol
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= {AW{1'b0}};
        end else if (adv) begin
            addr <= wrap ? {AW{1'b0}} : addr + AW'(1);
        end
    end

    assign wrap = (addr == AW'(TB_DEPTH - 1));
endmodule

// File: rtl/viterbi_acs_sched.sv
// Folded ACS scheduler: steps butterfly groups per symbol, ping-pongs metric
// banks, writes survivors and hands full windows to traceback.
// Optional feature macro: VITERBI_ACS_NORM_EN (path-metric normalization).
module viterbi_acs_sched
    import viterbi_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    rx_pair,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          acs_en,
    output logic [GW-1:0] acs_group,
    output logic [1:0]    acs_rx_pair,
    output logic          pm_rd_bank,
    output logic          sp_wr_en,
    output logic [AW-1:0] sp_wr_addr,
    output logic          tb_start,
    input  logic          tb_ready,
    input  logic          pm_msb_any,
    output logic          pm_norm
);
    sched_state_e state_r;
    logic         sp_wrap_s;
    logic         handshake_s;
    logic         last_run_s;

    assign rx_ready    = (state_r == IDLE);
    assign handshake_s = rx_ready && rx_valid;
    assign last_run_s  = (state_r == RUN) && is_last_group(acs_group);

    // sp_wr_en is high exactly in the last group cycle, so it doubles as advance
    viterbi_sp_addr_ctr u_sp_addr_ctr (
        .clk  (clk),
        .rst  (rst),
        .adv  (sp_wr_en),
        .addr (sp_wr_addr),
        .wrap (sp_wrap_s)
    );

    // Scheduler FSM with group counter, bank toggle and traceback hand-off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            acs_en      <= 1'b0;
            acs_group   <= {GW{1'b0}};
            acs_rx_pair <= 2'b00;
            pm_rd_bank  <= 1'b0;
            sp_wr_en    <= 1'b0;
            tb_start    <= 1'b0;
        end else begin
            sp_wr_en <= 1'b0;
            tb_start <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rx_valid) begin
                        state_r     <= RUN;
                        acs_en      <= 1'b1;
                        acs_group   <= {GW{1'b0}};
                        acs_rx_pair <= rx_pair;
                    end
                end
                RUN: begin
                    if (is_last_group(acs_group)) begin
                        acs_en     <= 1'b0;
                        acs_group  <= {GW{1'b0}};
                        pm_rd_bank <= ~pm_rd_bank;
                        if (sp_wrap_s && !tb_ready) begin
                            state_r <= TB_WAIT;
                        end else begin
                            state_r  <= IDLE;
                            tb_start <= sp_wrap_s;
                        end
                    end else begin
                        acs_group <= acs_group + GW'(1);
                        sp_wr_en  <= (acs_group == GW'(G - 2));
                    end
                end
                TB_WAIT: begin
                    if (tb_ready) begin
                        state_r  <= IDLE;
                        tb_start <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    acs_en  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VITERBI_ACS_NORM_EN
    logic norm_flag_r;

    // Sticky MSB flag; captured at handshake so a whole symbol normalizes together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            norm_flag_r <= 1'b0;
            pm_norm     <= 1'b0;
        end else if (handshake_s) begin
            pm_norm     <= norm_flag_r;
            norm_flag_r <= 1'b0;
        end else if (state_r == RUN) begin
            norm_flag_r <= norm_flag_r | pm_msb_any;
            if (last_run_s) begin
                pm_norm <= 1'b0;
            end
        end
    end
`else
    logic norm_unused_s;
    assign norm_unused_s = pm_msb_any ^ handshake_s ^ last_run_s;
    assign pm_norm       = 1'b0;
`endif
endmodule

// File: tb/tb_viterbi_acs_sched.sv
// Scoreboard bench for viterbi_acs_sched: expected survivor writes are queued
// at each handshake and checked as the scheduler steps the groups.
`timescale 1ns/1ps
module tb_viterbi_acs_sched;
    import viterbi_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    rx_pair = 2'b00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          acs_en;
    logic [GW-1:0] acs_group;
    logic [1:0]    acs_rx_pair;
    logic          pm_rd_bank;
    logic          sp_wr_en;
    logic [AW-1:0] sp_wr_addr;
    logic          tb_start;
    logic          tb_ready = 1'b1;
    logic          pm_msb_any = 1'b0;
    logic          pm_norm;

    viterbi_acs_sched dut (
        .clk(clk), .rst(rst), .rx_pair(rx_pair), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .acs_en(acs_en), .acs_group(acs_group),
        .acs_rx_pair(acs_rx_pair), .pm_rd_bank(pm_rd_bank), .sp_wr_en(sp_wr_en),
        .sp_wr_addr(sp_wr_addr), .tb_start(tb_start), .tb_ready(tb_ready),
        .pm_msb_any(pm_msb_any), .pm_norm(pm_norm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] pair;
        logic [4:0] addr;
        logic       bank;
        logic       norm;
    } exp_t;

    exp_t q[$];
    int   hs_times[$];
    exp_t e_push, e_pop;
    int   n_checks = 0, n_errors = 0;
    int   hs_cnt = 0, tb_cnt = 0, cyc = 0;
    int   m_addr = 0, grp_cnt = 0;
    logic m_bank = 1'b0, exp_norm = 1'b0, tbr_q = 1'b0;
    logic after_wr = 1'b0, wr_wrap = 1'b0, wait_mode = 1'b0, last_tb = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: queue the expected write for every accepted symbol
    always @(posedge clk) begin
        cyc++;
        tbr_q = tb_ready;
        if (rst) begin
            m_addr = 0;
            m_bank = 1'b0;
        end else if (rx_valid && rx_ready) begin
            e_push.pair = rx_pair;
            e_push.addr = m_addr[4:0];
            e_push.bank = m_bank;
            e_push.norm = exp_norm;
            q.push_back(e_push);
            hs_times.push_back(cyc);
            m_addr = (m_addr + 1) % TB_DEPTH;
            m_bank = ~m_bank;
            hs_cnt++;
        end
    end

    // Output checker on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            grp_cnt = 0;
            after_wr = 1'b0;
            wait_mode = 1'b0;
            last_tb = 1'b0;
        end else begin
            if (tb_start) tb_cnt++;
            chk("tb_double", {31'd0, tb_start & last_tb}, 32'd0);
            last_tb = tb_start;
            if (wait_mode) begin
                chk("tbw_start", {31'd0, tb_start}, {31'd0, tbr_q});
                chk("tbw_ready", {31'd0, rx_ready}, {31'd0, tb_start});
                if (tb_start) wait_mode = 1'b0;
            end else if (after_wr) begin
                if (wr_wrap) begin
                    chk("tb_pulse", {31'd0, tb_start}, {31'd0, tbr_q});
                    chk("rdy_after_wrap", {31'd0, rx_ready}, {31'd0, tbr_q});
                    if (!tbr_q) wait_mode = 1'b1;
                end else begin
                    chk("tb_nowrap", {31'd0, tb_start}, 32'd0);
                    chk("rdy_after_wr", {31'd0, rx_ready}, 32'd1);
                end
                after_wr = 1'b0;
            end
            if (acs_en) begin
                chk("rdy_run", {31'd0, rx_ready}, 32'd0);
                chk("group", 32'(acs_group), 32'(grp_cnt));
                chk("wr_en", {31'd0, sp_wr_en}, {31'd0, grp_cnt == G - 1});
                if (q.size() == 0) begin
                    chk("q_empty", 32'd0, 32'd1);
                end else begin
                    chk("pair", 32'(acs_rx_pair), 32'(q[0].pair));
                    chk("norm", {31'd0, pm_norm}, {31'd0, q[0].norm});
                    if (sp_wr_en) begin
                        e_pop = q.pop_front();
                        chk("wr_addr", 32'(sp_wr_addr), 32'(e_pop.addr));
                        chk("wr_bank", {31'd0, pm_rd_bank}, {31'd0, e_pop.bank});
                        after_wr = 1'b1;
                        wr_wrap = (e_pop.addr == 5'd31);
                    end
                end
                grp_cnt = (grp_cnt + 1) % G;
            end else begin
                chk("wr_idle", {31'd0, sp_wr_en}, 32'd0);
                chk("norm_idle", {31'd0, pm_norm}, 32'd0);
                grp_cnt = 0;
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_en"},   {31'd0, acs_en},     32'd0);
        chk({tag, "_grp"},  32'(acs_group),      32'd0);
        chk({tag, "_pair"}, 32'(acs_rx_pair),    32'd0);
        chk({tag, "_bank"}, {31'd0, pm_rd_bank}, 32'd0);
        chk({tag, "_wr"},   {31'd0, sp_wr_en},   32'd0);
        chk({tag, "_addr"}, 32'(sp_wr_addr),     32'd0);
        chk({tag, "_tb"},   {31'd0, tb_start},   32'd0);
        chk({tag, "_norm"}, {31'd0, pm_norm},    32'd0);
        chk({tag, "_rdy"},  {31'd0, rx_ready},   32'd1);
    endtask

    task automatic wait_hs(input int target, input int budget);
        for (int i = 0; i < budget && hs_cnt < target; i++) begin
            @(posedge clk);
            #1;
        end
        chk("hs_reached", {31'd0, hs_cnt >= target}, 32'd1);
    endtask

    // mode 1: pm_msb_any pulse during RUN; mode 2: rx_valid pulse while busy
    task automatic send_sym(input logic [1:0] p, input logic n, input int mode);
        int base;
        base = hs_cnt;
        @(negedge clk);
        rx_pair = p;
        rx_valid = 1'b1;
        exp_norm = n;
        wait_hs(base + 1, 20);
        rx_valid = 1'b0;
        if (mode == 1) begin
            @(negedge clk);
            pm_msb_any = 1'b1;
            @(negedge clk);
            pm_msb_any = 1'b0;
        end
        if (mode == 2) begin
            @(negedge clk);
            rx_pair = ~p;
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
        end
        repeat (6) @(negedge clk);
        chk("one_symbol", 32'(hs_cnt), 32'(base + 1));
    endtask

    initial begin
        int base, tb0;
        repeat (3) @(negedge clk);
        check_reset("rst0");
        #2 rst = 1'b0;

        // single symbol with rx_ready timing
        base = hs_cnt;
        @(negedge clk);
        rx_pair = 2'b10;
        rx_valid = 1'b1;
        wait_hs(base + 1, 20);
        rx_valid = 1'b0;
        for (int k = 1; k <= G + 1; k++) begin
            @(negedge clk);
            chk("rdy_single", {31'd0, rx_ready}, {31'd0, k == G + 1});
        end
        chk("bank_flip", {31'd0, pm_rd_bank}, 32'd1);
        chk("pair_hold", 32'(acs_rx_pair), 32'd2);
        chk("addr_adv", 32'(sp_wr_addr), 32'd1);

        // sustained stream, traceback always ready
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        base = hs_cnt;
        tb0 = tb_cnt;
        tb_ready = 1'b1;
        rx_valid = 1'b1;
        for (int i = 0; i < 400 && hs_cnt < base + 33; i++) begin
            @(posedge clk);
            #1;
            rx_pair = hs_cnt[1:0] ^ 2'b01;
        end
        rx_valid = 1'b0;
        chk("stream_hs", 32'(hs_cnt), 32'(base + 33));
        if (hs_times.size() > base + 31)
            chk("throughput", 32'(hs_times[base + 31] - hs_times[base]), 32'(31 * (G + 1)));
        else
            chk("throughput_len", 32'(hs_times.size()), 32'(base + 32));
        repeat (10) @(negedge clk);
        chk("tb_once", 32'(tb_cnt - tb0), 32'd1);

        // stream into a wrap with traceback busy
        base = hs_cnt;
        tb0 = tb_cnt;
        tb_ready = 1'b0;
        rx_valid = 1'b1;
        for (int i = 0; i < 400 && hs_cnt < base + 31; i++) begin
            @(posedge clk);
            #1;
            rx_pair = hs_cnt[1:0];
        end
        repeat (15) @(negedge clk);
        chk("wait_hold_hs", 32'(hs_cnt), 32'(base + 31));
        chk("wait_no_tb", 32'(tb_cnt - tb0), 32'd0);
        chk("wait_rdy", {31'd0, rx_ready}, 32'd0);
        tb_ready = 1'b1;
        wait_hs(base + 32, 20);
        rx_valid = 1'b0;
        chk("wait_tb_once", 32'(tb_cnt - tb0), 32'd1);
        repeat (6) @(negedge clk);

        // reset in the middle of a symbol
        base = hs_cnt;
        @(negedge clk);
        rx_pair = 2'b11;
        rx_valid = 1'b1;
        wait_hs(base + 1, 20);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("grp_pre_rst", 32'(acs_group), 32'd2);
        #2 rst = 1'b1;
        #1 check_reset("rst_mid");
        @(negedge clk);
        #2 rst = 1'b0;
        send_sym(2'b01, 1'b0, 0);
        chk("post_rst_addr", 32'(sp_wr_addr), 32'd1);

        // rx_valid while busy is ignored
        send_sym(2'b10, 1'b0, 2);

`ifdef VITERBI_ACS_NORM_EN
        for (int s = 1; s <= 7; s++)
            send_sym(2'(s), s == 6, (s == 5) ? 1 : 0);
`else
        for (int s = 1; s <= 3; s++)
            send_sym(2'(s), 1'b0, 1);
`endif

        chk("q_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/viterbi_acs_sched.md
# viterbi_acs_sched

Sequencer for the folded add-compare-select stage of the Viterbi decoder. It accepts one received symbol pair per handshake and steps the shared BMC/ACS butterfly array through all butterfly groups of the trellis. It also ping-pongs the path-metric banks, issues one survivor-memory write per symbol, and hands a full survivor window to traceback. It sits between the input symbol stream and the array of 2-bit branch-metric units feeding the ACS butterflies.

## Interface
- NUM_STATES, 64, trellis states; power of two, ≥4
- PAR, 8, butterflies evaluated per cycle; G = NUM_STATES/(2·PAR) groups, G ≥ 2
- TB_DEPTH, 32, survivor window depth in symbols; power of two
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_pair  in  2  received hard-decision symbol pair
- rx_valid  in  1  rx_pair valid
- rx_ready  out  1  scheduler can accept a symbol
- acs_en  out  1  butterfly array computes this cycle
- acs_group  out  clog2(G)  butterfly group index
- acs_rx_pair  out  2  latched symbol pair driven to all BMC units
- pm_rd_bank  out  1  path-metric bank read this symbol; the other bank is written
- sp_wr_en  out  1  survivor-memory write strobe
- sp_wr_addr  out  clog2(TB_DEPTH)  survivor-memory column
- tb_start  out  1  one-cycle pulse: survivor window complete
- tb_ready  in  1  traceback can accept a new window
- pm_msb_any  in  1  OR of path-metric MSBs (used only with VITERBI_ACS_NORM_EN)
- pm_norm  out  1  ACS subtracts normalization offset (only with VITERBI_ACS_NORM_EN)

## Operation
- States: IDLE, RUN, TB_WAIT.
- IDLE: rx_ready=1. On rx_valid&rx_ready, latch rx_pair into acs_rx_pair, set acs_group=0, go to RUN.
- RUN: acs_en=1 and rx_ready=0. acs_group increments each cycle.
- Last RUN cycle is acs_group=G-1. In that cycle sp_wr_en=1 at the current sp_wr_addr. On the following edge, toggle pm_rd_bank and advance sp_wr_addr mod TB_DEPTH.
- If the write was at sp_wr_addr=TB_DEPTH-1 (wrap), pulse tb_start in the next cycle:
  - tb_ready=1 in that cycle: return to IDLE.
  - tb_ready=0: enter TB_WAIT, hold rx_ready=0 and tb_start=0. Re-pulse tb_start for one cycle in the first cycle tb_ready=1, then go to IDLE.
- When not wrapping, the next state after the last RUN cycle is IDLE.
- acs_rx_pair holds its value outside RUN. rx_valid is ignored unless rx_ready=1.
- Reset (asynchronous, any state): state=IDLE, acs_en=0, acs_group=0, acs_rx_pair=0, pm_rd_bank=0, sp_wr_en=0, sp_wr_addr=0, tb_start=0, pm_norm=0. rx_ready=1 while state is IDLE.
- Reset in the middle of a symbol discards the symbol. No partial write is retained.

## Timing
- Handshake at edge T: acs_en is high in cycles T+1..T+G, with acs_group 0..G-1.
- sp_wr_en is high in cycle T+G.
- rx_ready=1 again in cycle T+G+1 (no wrap, or wrap with tb_ready=1).
- Sustained throughput: one symbol per G+1 cycles.
- tb_start fires in cycle T+G+1 at the earliest and is never high for two consecutive cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from rx_valid, tb_ready or pm_msb_any to any output.

## Configuration
- VITERBI_ACS_NORM_EN defined:
  - Sample pm_msb_any during RUN and OR it into a sticky flag.
  - Clear the flag at each handshake; its value at the handshake is captured and drives pm_norm=1 for all G acs_en cycles of that next symbol.
  - So all groups of one symbol normalize together, never part of a symbol.
- Not defined: pm_norm is tied to 0, pm_msb_any is unused, and no flag register exists.

## Structure
- Shared package viterbi_pkg holds:
  - NUM_STATES, PAR, TB_DEPTH defaults.
  - Derived G and the group/address widths.
  - The scheduler state enum {IDLE, RUN, TB_WAIT}.
- One natural sub-module: viterbi_sp_addr_ctr. It is the mod-TB_DEPTH survivor address counter, with wrap output driving tb_start generation.
- The FSM, group counter and bank toggle stay in viterbi_acs_sched.

## Test plan
All scenarios use the defaults, G=4.
- Reset then a single symbol rx_pair=2'b10: acs_en for 4 cycles with groups 0,1,2,3; acs_rx_pair=2'b10; sp_wr_en in the 4th cycle at addr 0; pm_rd_bank flips 0→1; rx_ready back at handshake+5.
- rx_valid held high for 32 symbols with tb_ready=1: sp_wr_addr runs 0..31 then 0; exactly one tb_start, in the cycle after the write at addr 31.
- Same as above with tb_ready=0 until 10 cycles after the wrap: FSM in TB_WAIT, rx_ready=0 throughout; tb_start pulses once, in the first cycle tb_ready=1; symbol 33 accepted next cycle.
- rst asserted mid-RUN at acs_group=2: all outputs return to reset values immediately; after release the next symbol writes addr 0 with pm_rd_bank=0.
- With VITERBI_ACS_NORM_EN, pm_msb_any=1 in one cycle of symbol 5: pm_norm=1 for all 4 acs_en cycles of symbol 6 and 0 for symbol 7.
- rx_valid pulsed while rx_ready=0: acs_rx_pair unchanged and no extra symbol processed.
